// File: rtl/avalon_uart_responder.sv
// Avalon-MM responder with the JTAG UART register map, backed by an 8N1 serial UART.
// One wait state per access; RX and TX are each buffered by a small byte FIFO.

module avalon_uart_responder_fifo #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    head,
  output logic [AW:0]   count,
  output logic          empty
);
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [7:0]  mem_r [DEPTH];
  logic [AW:0] wptr_r;
  logic [AW:0] rptr_r;
  logic        full_s;
  logic        push_ok_s;
  logic        pop_ok_s;

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign count     = wptr_r - rptr_r;
  assign empty     = (count == {(AW+1){1'b0}});
  assign full_s    = (count == (AW+1)'(DEPTH));
  assign push_ok_s = push && !full_s;
  assign pop_ok_s  = pop && !empty;
  assign head      = mem_r[rptr_r[AW-1:0]];

  // Pointer update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_r <= {(AW+1){1'b0}};
      rptr_r <= {(AW+1){1'b0}};
    end else begin
      if (push_ok_s) wptr_r <= wptr_r + PTR_ONE;
      if (pop_ok_s)  rptr_r <= rptr_r + PTR_ONE;
    end
  end

  // Storage array
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_r[wptr_r[AW-1:0]] <= push_data;
  end
endmodule

module avalon_uart_responder #(
  parameter int CLK_DIV = 434,
  parameter int FIFO_AW = 4
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        av_chipselect,
  input  logic        av_address,
  input  logic        av_read_n,
  input  logic        av_write_n,
  input  logic [31:0] av_writedata,
  output logic [31:0] av_readdata,
  output logic        av_waitrequest,
  output logic        irq_irq,
  output logic        uart_tx,
  input  logic        uart_rx
);
  localparam int BW    = $clog2(CLK_DIV);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BAUD_HALF = BW'(CLK_DIV / 2 - 1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_FERR} rx_state_t;

  // Bus side
  logic        ack_r;
  logic [31:0] readdata_r;
  logic        re_r;
  logic        we_r;
  logic        ac_r;
  logic        irq_r;
  logic        is_write_s;
  logic        is_read_s;
  logic        start_s;
  logic        done_s;
  logic        tx_push_s;
  logic        rx_pop_s;
  logic        ctrl_wr_s;
  logic [31:0] rd_next_s;
  logic [15:0] wspace_s;
  logic [15:0] ravail_s;
  logic        ri_s;
  logic        wi_s;
  logic        unused_s;

  // FIFO side
  logic [7:0]         tx_head_s;
  logic [FIFO_AW:0]   tx_count_s;
  logic               tx_empty_s;
  logic [7:0]         rx_head_s;
  logic [FIFO_AW:0]   rx_count_s;
  logic               rx_empty_s;

  // Serial side
  tx_state_t   tx_state_r;
  logic [BW-1:0] tx_baud_r;
  logic [2:0]  tx_bit_r;
  logic [7:0]  tx_shift_r;
  logic        tx_r;
  logic        tx_load_s;
  rx_state_t   rx_state_r;
  logic [BW-1:0] rx_baud_r;
  logic [2:0]  rx_bit_r;
  logic [7:0]  rx_shift_r;
  logic        rx_push_r;
  logic        rx_meta_r;
  logic        rx_sync_r;
  logic        rx_prev_r;

  // Simultaneous read and write strobes resolve to a write.
  assign is_write_s = !av_write_n;
  assign is_read_s  = !av_read_n && av_write_n;
  assign start_s    = av_chipselect && !ack_r;
  assign done_s     = av_chipselect && ack_r;
  assign tx_push_s  = done_s && is_write_s && !av_address;
  assign ctrl_wr_s  = done_s && is_write_s && av_address;
  assign rx_pop_s   = done_s && is_read_s && !av_address && readdata_r[15];

  assign av_waitrequest = start_s && reset_reset_n;
  assign av_readdata    = readdata_r;
  assign irq_irq        = irq_r;
  assign uart_tx        = tx_r;

  assign ri_s     = !rx_empty_s;
  assign wi_s     = tx_empty_s;
  assign wspace_s = 16'(DEPTH) - 16'(tx_count_s);
  assign ravail_s = 16'(rx_count_s) - 16'd1;
  assign unused_s = ^{av_writedata[31:11], av_writedata[9:8]};

  // A new frame starts whenever the line is free and a byte is waiting.
  assign tx_load_s = !tx_empty_s &&
                     ((tx_state_r == TX_IDLE) ||
                      ((tx_state_r == TX_STOP) && (tx_baud_r == {BW{1'b0}})));

  avalon_uart_responder_fifo #(.AW(FIFO_AW)) u_tx_fifo (
    .clk       (clk_clk),
    .rst_n     (reset_reset_n),
    .push      (tx_push_s),
    .push_data (av_writedata[7:0]),
    .pop       (tx_load_s),
    .head      (tx_head_s),
    .count     (tx_count_s),
    .empty     (tx_empty_s)
  );

  avalon_uart_responder_fifo #(.AW(FIFO_AW)) u_rx_fifo (
    .clk       (clk_clk),
    .rst_n     (reset_reset_n),
    .push      (rx_push_r),
    .push_data (rx_shift_r),
    .pop       (rx_pop_s),
    .head      (rx_head_s),
    .count     (rx_count_s),
    .empty     (rx_empty_s)
  );

  // Read data for the access presented this cycle
  always_comb begin
    rd_next_s = 32'h0000_0000;
    if (is_read_s) begin
      if (av_address) begin
        rd_next_s = {wspace_s, 5'b00000, ac_r, wi_s, ri_s, 6'b000000, we_r, re_r};
      end else if (!rx_empty_s) begin
        rd_next_s = {ravail_s, 1'b1, 7'b0000000, rx_head_s};
      end else begin
        rd_next_s = 32'h0000_0000;
      end
    end else begin
      rd_next_s = 32'h0000_0000;
    end
  end

  // Handshake, control register and interrupt
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      ack_r      <= 1'b0;
      readdata_r <= 32'h0000_0000;
      re_r       <= 1'b0;
      we_r       <= 1'b0;
      irq_r      <= 1'b0;
    end else begin
      ack_r <= start_s;
      if (start_s) readdata_r <= rd_next_s;
      if (ctrl_wr_s) begin
        re_r <= av_writedata[0];
        we_r <= av_writedata[1];
      end
      irq_r <= (re_r && ri_s) || (we_r && wi_s);
    end
  end

  // Activity flag: a start bit outranks a clear in the same cycle
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      ac_r <= 1'b0;
    end else if (tx_load_s) begin
      ac_r <= 1'b1;
    end else if (ctrl_wr_s && av_writedata[10]) begin
      ac_r <= 1'b0;
    end
  end

  // Transmit state machine, LSB first
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      tx_state_r <= TX_IDLE;
      tx_baud_r  <= {BW{1'b0}};
      tx_bit_r   <= 3'd0;
      tx_shift_r <= 8'h00;
      tx_r       <= 1'b1;
    end else if (tx_load_s) begin
      tx_state_r <= TX_START;
      tx_baud_r  <= BAUD_LAST;
      tx_shift_r <= tx_head_s;
      tx_r       <= 1'b0;
    end else begin
      case (tx_state_r)
        TX_IDLE: tx_r <= 1'b1;
        TX_START: begin
          if (tx_baud_r == {BW{1'b0}}) begin
            tx_state_r <= TX_DATA;
            tx_baud_r  <= BAUD_LAST;
            tx_bit_r   <= 3'd0;
            tx_r       <= tx_shift_r[0];
            tx_shift_r <= {1'b0, tx_shift_r[7:1]};
          end else begin
            tx_baud_r <= tx_baud_r - BAUD_ONE;
          end
        end
        TX_DATA: begin
          if (tx_baud_r == {BW{1'b0}}) begin
            tx_baud_r <= BAUD_LAST;
            if (tx_bit_r == 3'd7) begin
              tx_state_r <= TX_STOP;
              tx_r       <= 1'b1;
            end else begin
              tx_bit_r   <= tx_bit_r + 3'd1;
              tx_r       <= tx_shift_r[0];
              tx_shift_r <= {1'b0, tx_shift_r[7:1]};
            end
          end else begin
            tx_baud_r <= tx_baud_r - BAUD_ONE;
          end
        end
        TX_STOP: begin
          if (tx_baud_r == {BW{1'b0}}) begin
            tx_state_r <= TX_IDLE;
          end else begin
            tx_baud_r <= tx_baud_r - BAUD_ONE;
          end
        end
        default: begin
          tx_state_r <= TX_IDLE;
          tx_r       <= 1'b1;
        end
      endcase
    end
  end

  // Two-stage synchronizer plus previous sample for edge detection
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= uart_rx;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // Receive state machine sampling at bit centres
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rx_state_r <= RX_IDLE;
      rx_baud_r  <= {BW{1'b0}};
      rx_bit_r   <= 3'd0;
      rx_shift_r <= 8'h00;
      rx_push_r  <= 1'b0;
    end else begin
      rx_push_r <= 1'b0;
      case (rx_state_r)
        RX_IDLE: begin
          if (rx_prev_r && !rx_sync_r) begin
            rx_state_r <= RX_START;
            rx_baud_r  <= BAUD_HALF;
          end
        end
        RX_START: begin
          if (rx_baud_r == {BW{1'b0}}) begin
            if (!rx_sync_r) begin
              rx_state_r <= RX_DATA;
              rx_baud_r  <= BAUD_LAST;
              rx_bit_r   <= 3'd0;
            end else begin
              rx_state_r <= RX_IDLE;
            end
          end else begin
            rx_baud_r <= rx_baud_r - BAUD_ONE;
          end
        end
        RX_DATA: begin
          if (rx_baud_r == {BW{1'b0}}) begin
            rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
            rx_baud_r  <= BAUD_LAST;
            if (rx_bit_r == 3'd7) begin
              rx_state_r <= RX_STOP;
            end else begin
              rx_bit_r <= rx_bit_r + 3'd1;
            end
          end else begin
            rx_baud_r <= rx_baud_r - BAUD_ONE;
          end
        end
        RX_STOP: begin
          if (rx_baud_r == {BW{1'b0}}) begin
            if (rx_sync_r) begin
              rx_push_r  <= 1'b1;
              rx_state_r <= RX_IDLE;
            end else begin
              rx_state_r <= RX_FERR;
            end
          end else begin
            rx_baud_r <= rx_baud_r - BAUD_ONE;
          end
        end
        RX_FERR: begin
          if (rx_sync_r) rx_state_r <= RX_IDLE;
        end
        default: rx_state_r <= RX_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_avalon_uart_responder.sv
// Directed bench for avalon_uart_responder: bus handshake, TX framing, RX capture,
// FIFO limits, interrupts and mid-frame reset, checked against byte scoreboards.
module tb_avalon_uart_responder;
  localparam int CLK_DIV = 8;
  localparam logic [31:0] NO_WI = 32'hFFFF_FDFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cs = 1'b0;
  logic        adr = 1'b0;
  logic        rd_n = 1'b1;
  logic        wr_n = 1'b1;
  logic [31:0] wd = 32'h0;
  logic        rx = 1'b1;
  logic [31:0] readdata;
  logic        waitreq;
  logic        irq;
  logic        tx;

  int n_assert = 0;
  int n_fail = 0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  int   rst_epoch = 0;
  int   tx_seen = 0;
  logic mon_busy = 1'b0;
  logic [7:0]  mon_b;
  logic        mon_ok;
  int          mon_ep;
  logic [31:0] mon_exp;

  avalon_uart_responder #(.CLK_DIV(CLK_DIV), .FIFO_AW(4)) dut (
    .clk_clk        (clk),
    .reset_reset_n  (rst_n),
    .av_chipselect  (cs),
    .av_address     (adr),
    .av_read_n      (rd_n),
    .av_write_n     (wr_n),
    .av_writedata   (wd),
    .av_readdata    (readdata),
    .av_waitrequest (waitreq),
    .irq_irq        (irq),
    .uart_tx        (tx),
    .uart_rx        (rx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One access; waitrequest must be high for exactly the first cycle.
  task automatic bus(input logic a, input logic w, input logic [31:0] d,
                     output logic [31:0] r, input bit keep);
    cs = 1'b1; adr = a; wr_n = !w; rd_n = w; wd = d;
    #1 check("waitreq_cycle1", {31'h0, waitreq}, 32'h1);
    @(posedge clk); #1;
    check("waitreq_cycle2", {31'h0, waitreq}, 32'h0);
    r = readdata;
    @(posedge clk); #1;
    if (!keep) begin cs = 1'b0; rd_n = 1'b1; wr_n = 1'b1; end
  endtask

  task automatic read_rx(input string tag);
    logic [31:0] r;
    logic [31:0] e;
    logic [7:0]  b;
    if (rx_q.size() > 0) begin
      b = rx_q.pop_front();
      e = {16'(rx_q.size()), 1'b1, 7'h00, b};
    end else begin
      e = 32'h0;
    end
    bus(1'b0, 1'b0, 32'h0, r, 1'b0);
    check(tag, r, e);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CLK_DIV) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CLK_DIV) @(posedge clk);
      #1;
    end
    rx = stop;
    repeat (CLK_DIV) @(posedge clk);
    #1 rx = 1'b1;
    repeat (2 * CLK_DIV) @(posedge clk);
    #1;
  endtask

  task automatic wait_tx_done(input string tag);
    int n;
    n = 0;
    while ((tx_q.size() != 0 || mon_busy) && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, tx_q.size(), 32'h0);
  endtask

  // Serial monitor: decodes each frame at bit centres and scores it.
  always begin
    @(negedge tx);
    mon_busy = 1'b1;
    mon_ep = rst_epoch;
    repeat (CLK_DIV / 2) @(posedge clk);
    #1 mon_ok = (tx == 1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat (CLK_DIV) @(posedge clk);
      #1 mon_b[i] = tx;
    end
    repeat (CLK_DIV) @(posedge clk);
    #1 mon_ok = mon_ok && tx;
    if (mon_ep == rst_epoch) begin
      tx_seen++;
      if (tx_q.size() > 0) mon_exp = {23'h0, 1'b1, tx_q.pop_front()};
      else mon_exp = 32'hDEAD_BEEF;
      check("tx_frame", {23'h0, mon_ok, mon_b}, mon_exp);
    end
    mon_busy = 1'b0;
  end

  initial begin
    logic [31:0] r;
    int n;
    logic [7:0] b;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", {31'h0, tx}, 32'h1);
    check("rst_waitreq", {31'h0, waitreq}, 32'h0);
    check("rst_readdata", readdata, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Single byte 0x41: timing of start bit, then AC and WSPACE
    tx_q.push_back(8'h41);
    bus(1'b0, 1'b1, 32'h0000_0041, r, 1'b0);
    check("tx_idle_at_push", {31'h0, tx}, 32'h1);
    @(posedge clk); #1;
    check("tx_start_bit", {31'h0, tx}, 32'h0);
    n = 0;
    while (tx == 1'b0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("start_bit_len", n, 32'd8);
    bus(1'b1, 1'b0, 32'h0, r, 1'b0);
    check("ctrl_ac_set", r & NO_WI, 32'h0010_0400);
    bus(1'b1, 1'b1, 32'h0000_0400, r, 1'b0);
    bus(1'b1, 1'b0, 32'h0, r, 1'b0);
    check("ctrl_ac_clear", r & NO_WI, 32'h0010_0000);
    wait_tx_done("tx_single_drained");

    // Receive 0x5A
    rx_q.push_back(8'h5A);
    send_rx(8'h5A, 1'b1);
    read_rx("rx_5a");
    read_rx("rx_empty");

    // Burst of 17 writes while the first byte is on the line
    tx_q.push_back(8'hA0);
    bus(1'b0, 1'b1, 32'h0000_00A0, r, 1'b0);
    @(posedge clk); #1;
    bus(1'b1, 1'b0, 32'h0, r, 1'b0);
    check("burst_first_popped", r & NO_WI, 32'h0010_0400);
    for (int i = 0; i < 17; i++) begin
      b = 8'hB0 + 8'(i);
      if (i < 16) tx_q.push_back(b);
      bus(1'b0, 1'b1, {24'h0, b}, r, (i < 16));
    end
    bus(1'b1, 1'b0, 32'h0, r, 1'b0);
    check("burst_fifo_full", r & NO_WI, 32'h0000_0400);
    wait_tx_done("tx_burst_drained");
    check("tx_frame_count", tx_seen, 32'd18);

    // Three received bytes, RAVAIL countdown and RX interrupt
    for (int i = 0; i < 3; i++) begin
      b = 8'h11 * 8'(i + 1);
      rx_q.push_back(b);
      send_rx(b, 1'b1);
    end
    check("irq_masked", {31'h0, irq}, 32'h0);
    bus(1'b1, 1'b1, 32'h0000_0001, r, 1'b0);
    @(posedge clk); #1;
    check("irq_rise", {31'h0, irq}, 32'h1);
    read_rx("ravail_2");
    read_rx("ravail_1");
    check("irq_still_high", {31'h0, irq}, 32'h1);
    read_rx("ravail_0");
    @(posedge clk); #1;
    check("irq_fall", {31'h0, irq}, 32'h0);
    bus(1'b1, 1'b1, 32'h0000_0000, r, 1'b0);

    // Framing error then a good byte; then a one-cycle glitch
    send_rx(8'h33, 1'b0);
    rx_q.push_back(8'h44);
    send_rx(8'h44, 1'b1);
    read_rx("rx_after_ferr");
    read_rx("rx_ferr_dropped");
    rx = 1'b0;
    @(posedge clk); #1 rx = 1'b1;
    repeat (4 * CLK_DIV) @(posedge clk);
    #1;
    read_rx("rx_glitch_ignored");

    // Reset in the middle of a transmitted byte, with an access pending
    tx_q.push_back(8'h55);
    bus(1'b0, 1'b1, 32'h0000_0055, r, 1'b0);
    repeat (30) @(posedge clk);
    #1;
    cs = 1'b1; adr = 1'b1; rd_n = 1'b0; wr_n = 1'b1;
    rst_epoch++;
    tx_q.delete();
    rst_n = 1'b0;
    #1;
    check("midreset_tx", {31'h0, tx}, 32'h1);
    check("midreset_waitreq", {31'h0, waitreq}, 32'h0);
    cs = 1'b0; rd_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    bus(1'b1, 1'b0, 32'h0, r, 1'b0);
    check("post_reset_ctrl", r & NO_WI, 32'h0010_0000);
    repeat (12 * CLK_DIV) @(posedge clk);
    #1;
    check("post_reset_tx_idle", {31'h0, tx}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
